// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Optional macro ARB_RR_EN: on simultaneous requests the requester not served
// last wins; otherwise data always has priority over fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
`ifdef ARB_RR_EN
  input  owner_e last_owner,
`endif
  output logic   valid,
  output owner_e owner
);

  // Pick a winner from the current requests.
  always_comb begin
    valid = if_req | d_req;
`ifdef ARB_RR_EN
    if (if_req && d_req) begin
      owner = (last_owner == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else begin
      owner = if_req ? OWN_FETCH : OWN_DATA;
    end
`else
    owner = d_req ? OWN_DATA : OWN_FETCH;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// data load/store. One transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LAT
// -> RESP. All outputs are registered.
// Optional macro ARB_RR_EN: alternate owners on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_e           owner_q;
  logic             we_q;
  logic             pick_valid;
  owner_e           pick_owner;
  logic             issue, capture;

  logic              if_gnt_d, if_rvalid_d, d_gnt_d, d_rvalid_d;
  logic              mem_en_d, mem_we_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

`ifdef ARB_RR_EN
  owner_e last_q;

  // Remember who was served last; updated as each transaction is issued.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      last_q <= OWN_DATA;
    end else if (state_q == ISSUE) begin
      last_q <= owner_q;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef ARB_RR_EN
    .last_owner (last_q),
`endif
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  // State register and latency counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; WAIT counts down from MEM_LAT-1 to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (pick_valid) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    issue       = (state_q == IDLE) && pick_valid;
    capture     = (state_q == WAIT) && (cnt_q == '0);
    if_gnt_d    = issue && (pick_owner == OWN_FETCH);
    d_gnt_d     = issue && (pick_owner == OWN_DATA);
    mem_en_d    = issue;
    mem_we_d    = d_gnt_d && d_we;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (if_gnt_d) mem_addr_d = if_addr;
    if (d_gnt_d) begin
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end
    if_rvalid_d = capture && (owner_q == OWN_FETCH);
    d_rvalid_d  = capture && (owner_q == OWN_DATA);
    if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata;
    // Stores complete with a pulse but leave the load data untouched.
    d_rdata_d   = (d_rvalid_d && !we_q) ? mem_rdata : d_rdata;
    busy_d      = (state_d != IDLE);
  end

  // Transaction context latched when a winner is picked.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      owner_q <= OWN_DATA;
      we_q    <= 1'b0;
    end else if (issue) begin
      owner_q <= pick_owner;
      we_q    <= (pick_owner == OWN_DATA) && d_we;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= if_gnt_d;
      if_rvalid <= if_rvalid_d;
      if_rdata  <= if_rdata_d;
      d_gnt     <= d_gnt_d;
      d_rvalid  <= d_rvalid_d;
      d_rdata   <= d_rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the PC/instruction-fetch path and the data-memory control signals (memory read, memory write) and the physical memory array.
- Arbitrates, issues one transaction at a time, waits the memory latency, then returns data and a completion pulse to the owner.

Parameters:
ADDR_W, 32, address width (word address; the PC increments by 1)
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range >= 1

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request; held with if_addr until its if_rvalid cycle inclusive
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch transaction issued
if_rdata  out  DATA_W  fetched instruction, valid with if_rvalid, held afterwards
if_rvalid  out  1  one-cycle completion pulse
d_req  in  1  data request; held with d_we/d_addr/d_wdata until its d_rvalid cycle inclusive
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data transaction issued
d_rdata  out  DATA_W  load data, valid with d_rvalid, held afterwards
d_rvalid  out  1  one-cycle completion pulse (loads and stores)
mem_en  out  1  memory access strobe, exactly one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset value of every output is 0. State is IDLE. Owner is none. The last-owner bit is 0 (data).
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples requests and picks a winner.
  - Fixed priority: data over fetch.
  - Latches owner, address, we and wdata, then moves to ISSUE.
  - With no request, stays in IDLE.
- ISSUE (1 cycle):
  - Owner's gnt = 1 and mem_en = 1.
  - mem_we = latched we; always 0 for fetch.
  - mem_addr and mem_wdata driven from the latched values.
  - Moves to WAIT.
- WAIT (exactly MEM_LAT cycles):
  - Down-counter with width clog2(MEM_LAT+1).
  - In the last WAIT cycle, mem_rdata is captured into the owner's rdata register.
  - A store does not update d_rdata.
  - Moves to RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1.
  - Moves to IDLE.
  - Requests present during RESP are ignored.
- Timing: request seen in IDLE at cycle T gives gnt/mem_en at T+1, rvalid at T+2+MEM_LAT and IDLE again at T+3+MEM_LAT.
- Throughput: one transaction per MEM_LAT+3 cycles.
- A req still high in IDLE after its rvalid is a new transaction (back-to-back).
- mem_addr, mem_wdata and mem_we return to 0 when mem_en = 0.
- Simultaneous if_req and d_req in IDLE: data wins. Fetch stays pending and is granted in the next IDLE if still requested.
- A request dropped before gnt is simply not served. Requesters must not drop req between gnt and rvalid; the arbiter completes the transaction regardless.
- Asynchronous Rst in any state: immediate return to IDLE with all outputs 0. An in-flight transaction is abandoned and produces no rvalid.

Optional Feature:
ARB_RR_EN
- Defined: a last-owner bit is updated at each ISSUE. On simultaneous requests, the requester not served last wins.
- Undefined: fixed data-over-fetch priority. The last-owner bit is not implemented.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - owner encoding (OWN_DATA = 1'b0, OWN_FETCH = 1'b1)
- One sub-module, mem_arb_pick: combinational winner selection from if_req, d_req and last-owner. It contains the ARB_RR_EN variant, so the FSM is unchanged by the macro.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10 at cycle 1; memory returns 0xA5A50001.
  Required: if_gnt and mem_en with mem_addr=0x10, mem_we=0 at cycle 2; if_rvalid=1, if_rdata=0xA5A50001 at cycle 5; busy cycles 2-5.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF.
  Required: one mem_en cycle with mem_we=1 and the given address/data; d_rvalid pulses once; d_rdata unchanged; if_rvalid stays 0.
- Simultaneous if_req (0x4) and d_req (load 0x30), both held.
  Required without ARB_RR_EN: data served first, then fetch.
  Required with ARB_RR_EN: persistent dual requests alternate, fetch/data.
- Back-to-back: if_req held high across if_rvalid with if_addr incremented 0x0 to 0x1.
  Required: second if_gnt exactly 2 cycles after the first if_rvalid.
- Reset mid-WAIT: Rst asserted asynchronously during WAIT.
  Required: all outputs 0 immediately; no rvalid after release; a new request is served normally.
- MEM_LAT=1: a fetch completes with rvalid at T+3; mem_rdata is captured from the single WAIT cycle.
